// File: rtl/dot_8_sched_pkg.sv
// Shared types and constants for the dot_8 row-interleaving scheduler.
package dot_8_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] FP_ZERO        = 32'h0000_0000;
    localparam int          DEFAULT_LAT    = 24;
    localparam int          DEFAULT_RD_LAT = 2;

endpackage

// File: rtl/param_delay.sv
// Fixed-depth shift register with synchronous clear; DEPTH=0 degenerates to a wire.
module param_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stage[0] <= '0;
                end else begin
                    r_stage[0] <= din;
                end
            end

            for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_stage[gi] <= '0;
                    end else begin
                        r_stage[gi] <= r_stage[gi-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dot_8_sched.sv
// Issues LAT interleaved rows chunk-major into a LAT-deep dot_8 pipeline and
// routes each row's partial sum back as running_sum until its last chunk.
module dot_8_sched
    import dot_8_sched_pkg::*;
#(
    parameter int LAT    = DEFAULT_LAT,
    parameter int RD_LAT = DEFAULT_RD_LAT,
    parameter int ROW_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      num_chunks,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [ROW_W-1:0] rd_row,
    output logic [15:0]      rd_chunk,
    output logic             dot_en,
    input  logic [31:0]      dot_result,
    output logic [31:0]      running_sum,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row,
    output logic [31:0]      out_data
);

    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(LAT - 1);
    localparam logic [15:0]      DRAIN_LAST = 16'(RD_LAT + LAT - 1);

    state_t           r_state;
    logic [15:0]      r_num_chunks;
    logic [ROW_W-1:0] r_row;
    logic [15:0]      r_chunk;
    logic [15:0]      r_drain_cnt;

    logic             w_issue;
    logic             w_last_chunk;
    logic             w_first_in;
    logic             w_first_d;
    logic [ROW_W:0]   w_last_in;
    logic [ROW_W:0]   w_last_mid;
    logic [ROW_W:0]   w_last_d;

    // The chunk counter stops at num_chunks-1, so 16'hFFFF never wraps it.
    assign w_last_chunk = (r_chunk == (r_num_chunks - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_num_chunks <= '0;
            r_row        <= '0;
            r_chunk      <= '0;
            r_drain_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num_chunks <= num_chunks;
                        r_row        <= '0;
                        r_chunk      <= '0;
                        r_state      <= (num_chunks == 16'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_row == ROW_LAST) begin
                        r_row <= '0;
                        if (w_last_chunk) begin
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN;
                        end else begin
                            r_chunk <= r_chunk + 16'd1;
                        end
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 16'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_issue  = (r_state == ISSUE);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign rd_en    = w_issue;
    assign rd_row   = w_issue ? r_row : '0;
    assign rd_chunk = w_issue ? r_chunk : '0;
    assign dot_en   = w_issue || (r_state == DRAIN);

    assign w_first_in = w_issue && (r_chunk == 16'd0);
    assign w_last_in  = {w_issue && w_last_chunk, r_row};

    param_delay #(.WIDTH(1), .DEPTH(RD_LAT)) u_first_dly (
        .clk   (clk),
        .reset (reset),
        .din   (w_first_in),
        .dout  (w_first_d)
    );

    // Last-chunk tag follows the operands (RD_LAT) and then the dot pipeline (LAT).
    param_delay #(.WIDTH(1 + ROW_W), .DEPTH(RD_LAT)) u_last_rd_dly (
        .clk   (clk),
        .reset (reset),
        .din   (w_last_in),
        .dout  (w_last_mid)
    );

    param_delay #(.WIDTH(1 + ROW_W), .DEPTH(LAT)) u_last_lat_dly (
        .clk   (clk),
        .reset (reset),
        .din   (w_last_mid),
        .dout  (w_last_d)
    );

    assign running_sum = (dot_en && !w_first_d) ? dot_result : FP_ZERO;
    assign out_valid   = w_last_d[ROW_W];
    assign out_row     = w_last_d[ROW_W] ? w_last_d[ROW_W-1:0] : '0;
    assign out_data    = w_last_d[ROW_W] ? dot_result : FP_ZERO;

endmodule

// File: tb/tb_dot_8_sched.sv
// Scoreboard bench for dot_8_sched with a behavioural dot_8 pipeline model.
module tb_dot_8_sched;
    import dot_8_sched_pkg::*;

    localparam int LAT    = 24;
    localparam int RD_LAT = 2;
    localparam int ROW_W  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [15:0]      num_chunks;
    logic             busy, done, rd_en, dot_en, out_valid;
    logic [ROW_W-1:0] rd_row, out_row;
    logic [15:0]      rd_chunk;
    logic [31:0]      dot_result = 32'h0;
    logic [31:0]      running_sum, out_data;

    always #5 clk = ~clk;

    dot_8_sched #(.LAT(LAT), .RD_LAT(RD_LAT), .ROW_W(ROW_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_chunks  (num_chunks),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_chunk    (rd_chunk),
        .dot_en      (dot_en),
        .dot_result  (dot_result),
        .running_sum (running_sum),
        .out_valid   (out_valid),
        .out_row     (out_row),
        .out_data    (out_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit mon_on     = 1'b0;
    bit job_active = 1'b0;
    bit uniform    = 1'b0;
    int t0, rd_cnt, out_cnt, done_cnt, done_rel, first_out_rel, exp_row, exp_chunk;

    logic [ROW_W+31:0] sb_q [$];

    bit          ad_v     [RD_LAT];
    int          ad_row   [RD_LAT];
    int          ad_chunk [RD_LAT];
    logic [31:0] pipe     [LAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] int_to_fp(input int n);
        int          e;
        logic [31:0] m;
        if (n <= 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if (n[i]) e = i;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int fp_to_int(input logic [31:0] f);
        int          e;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'h00, 1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    // Sum of the eight products of one row/chunk (all-ones operands give 8).
    function automatic int contrib(input int r, input int c);
        return uniform ? 8 : (r + c + 1);
    endfunction

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        dot_result <= pipe[LAT-1];
    end

    always @(negedge clk) begin
        int          rel;
        bit          arr;
        int          arow, achk;
        logic [31:0] nv;
        logic [ROW_W+31:0] ent;
        if (mon_on) begin
            if (job_active) begin
                rel = cyc - t0;
                chk("busy", busy, 32'(rel >= 1 && rel <= done_rel));
                chk("dot_en", dot_en, 32'(rel >= 1 && rel < done_rel));
                if (rd_en) begin
                    chk("rd_slot", rel, 1 + rd_cnt);
                    chk("rd_row", rd_row, exp_row);
                    chk("rd_chunk", rd_chunk, exp_chunk);
                    rd_cnt++;
                    if (exp_row == LAT - 1) begin
                        exp_row = 0;
                        exp_chunk++;
                    end else begin
                        exp_row++;
                    end
                end
                if (out_valid) begin
                    chk("out_slot", rel, first_out_rel + out_cnt);
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        ent = sb_q.pop_front();
                        chk("out_row", out_row, ent[ROW_W+31:32]);
                        chk("out_data", out_data, ent[31:0]);
                    end
                    out_cnt++;
                end else begin
                    chk("out_row_idle", out_row, 0);
                    chk("out_data_idle", out_data, 0);
                end
                if (done) begin
                    chk("done_rel", rel, done_rel);
                    done_cnt++;
                end
            end else begin
                chk("idle_ctl", {busy, rd_en, dot_en, done, out_valid}, 0);
                chk("idle_sum", running_sum, 0);
                chk("idle_data", out_data, 0);
            end

            // dot_8 model: operands arrive RD_LAT after issue, result LAT later.
            arr  = ad_v[RD_LAT-1];
            arow = ad_row[RD_LAT-1];
            achk = ad_chunk[RD_LAT-1];
            nv   = 32'h0;
            if (arr) begin
                if (achk == 0) chk("rsum_zero", running_sum, FP_ZERO);
                else           chk("rsum_fb", running_sum, dot_result);
                nv = int_to_fp(fp_to_int(running_sum) + contrib(arow, achk));
            end
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = nv;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                ad_v[i]     = ad_v[i-1];
                ad_row[i]   = ad_row[i-1];
                ad_chunk[i] = ad_chunk[i-1];
            end
            ad_v[0]     = rd_en;
            ad_row[0]   = int'(rd_row);
            ad_chunk[0] = int'(rd_chunk);
        end
    end

    task automatic clear_model();
        for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
        for (int i = 0; i < RD_LAT; i++) begin
            ad_v[i]     = 1'b0;
            ad_row[i]   = 0;
            ad_chunk[i] = 0;
        end
    endtask

    // Starts a job in the current cycle; returns in the first cycle after done.
    task automatic run_job(input int nc, input bit uni, input bit hold,
                           input int glitch_at, input int rst_at);
        int sum, rel;
        logic [31:0] ev;
        uniform = uni;
        sb_q.delete();
        if (nc > 0) begin
            for (int r = 0; r < LAT; r++) begin
                sum = 0;
                for (int c = 0; c < nc; c++) sum += contrib(r, c);
                ev = (uni && nc == 3) ? 32'h41C0_0000 : int_to_fp(sum);
                sb_q.push_back({ROW_W'(r), ev});
            end
        end
        t0            = cyc;
        rd_cnt        = 0;
        out_cnt       = 0;
        done_cnt      = 0;
        exp_row       = 0;
        exp_chunk     = 0;
        done_rel      = (nc == 0) ? 1 : nc * LAT + RD_LAT + LAT + 1;
        first_out_rel = 1 + (nc - 1) * LAT + RD_LAT + LAT;
        num_chunks    = 16'(nc);
        start         = 1'b1;
        job_active    = 1'b1;
        for (int k = 0; k < done_rel + 20 && done_cnt == 0; k++) begin
            @(posedge clk);
            #1;
            rel = cyc - t0;
            if (!hold) start = 1'b0;
            if (glitch_at > 0 && rel == glitch_at) begin
                start      = 1'b1;
                num_chunks = 16'd5;
            end else if (glitch_at > 0 && rel == glitch_at + 1) begin
                start      = hold;
                num_chunks = 16'(nc);
            end
            if (rst_at > 0 && rel == rst_at) reset = 1'b1;
            if (rst_at > 0 && rel == rst_at + 1) begin
                reset      = 1'b0;
                job_active = 1'b0;
                sb_q.delete();
                clear_model();
                return;
            end
        end
        chk("done_seen", done_cnt, 1);
        chk("rd_count", rd_cnt, nc * LAT);
        chk("out_count", out_cnt, (nc > 0) ? LAT : 0);
        chk("sb_left", sb_q.size(), 0);
        $display("job nc=%0d start=%0d rd=%0d out=%0d done_at=%0d", nc, t0, rd_cnt, out_cnt, done_rel);
    endtask

    initial begin
        int base;
        clear_model();
        reset      = 1'b1;
        start      = 1'b0;
        num_chunks = 16'h0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        run_job(1, 1'b0, 1'b0, 0, 0);
        run_job(3, 1'b1, 1'b0, 0, 0);
        run_job(0, 1'b0, 1'b0, 0, 0);
        run_job(2, 1'b0, 1'b0, 10, 0);

        base = cyc;
        run_job(2, 1'b0, 1'b0, 0, 30);
        while (cyc < base + 40) begin @(posedge clk); #1; end
        run_job(1, 1'b0, 1'b0, 0, 0);

        run_job(2, 1'b0, 1'b1, 0, 0);
        run_job(1, 1'b0, 1'b1, 0, 0);
        run_job(3, 1'b0, 1'b0, 0, 0);

        job_active = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
